// File: rtl/tx_bytes_pkg.sv
// Shared tx/rx frame definitions: header layout, length limits, CRC defaults, FSM states.
package tx_bytes_pkg;

    localparam logic [8:0] OFS_SRC = 9'd0;
    localparam logic [8:0] OFS_DST = 9'd1;
    localparam logic [8:0] OFS_LEN = 9'd2;
    localparam logic [8:0] HDR_LEN = 9'd3;
    localparam logic [8:0] CRC_LEN = 9'd2;

    localparam logic [8:0] MAX_LEN_CRC  = 9'd253;
    localparam logic [8:0] MAX_LEN_USER = 9'd251;

    // byte_cnt of the final payload byte / final RAM byte relative to data_len
    localparam logic [8:0] LAST_PAY_OFS  = HDR_LEN - 9'd1;
    localparam logic [8:0] LAST_USER_OFS = HDR_LEN + CRC_LEN - 9'd1;

    localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_DEF = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_CRC_L,
        ST_CRC_H,
        ST_FIN
    } tx_state_t;

endpackage

// File: rtl/tx_bytes_crc16_byte.sv
// One-byte update of the reflected CRC-16; shared with the receive path.
module crc16_byte
    import tx_bytes_pkg::*;
#(
    parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc ^ {8'h00, i_data};
        for (int unsigned i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/tx_bytes.sv
// Frame transmitter: reads one frame from the TX RAM and streams it to the serializer,
// appending the CRC-16 unless the frame carries its own.
module tx_bytes
    import tx_bytes_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = CRC_INIT_DEF,
    parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       user_crc,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_byte,
    output logic [7:0] ser_data,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last
);

    tx_state_t   r_state,   w_state_nxt;
    logic [7:0]  r_rd_addr, w_rd_addr_nxt;
    logic [8:0]  r_cnt,     w_cnt_nxt;
    logic [7:0]  r_len,     w_len_nxt;
    logic [15:0] r_crc,     w_crc_nxt;
    logic [7:0]  r_data,    w_data_nxt;
    logic        r_valid,   w_valid_nxt;
    logic        r_last,    w_last_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_error,   w_error_nxt;

    logic        w_hs;
    logic [8:0]  w_len_eff;
    logic [8:0]  w_cnt_inc;
    logic [15:0] w_crc_upd;

    crc16_byte #(.CRC_POLY(CRC_POLY)) u_crc (
        .i_crc  (r_crc),
        .i_data (r_data),
        .o_crc  (w_crc_upd)
    );

    assign w_hs      = r_valid & ser_ready;
    // data_len register is only written on the LEN handshake, so use the byte itself then
    assign w_len_eff = (r_cnt == OFS_LEN) ? {1'b0, r_data} : {1'b0, r_len};
    assign w_cnt_inc = r_cnt + 9'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_addr_nxt = r_rd_addr;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_crc_nxt     = r_crc;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_rd_addr_nxt = '0;
                        w_cnt_nxt     = '0;
                        w_crc_nxt     = CRC_INIT;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = ST_WAIT;
                    end
                end
                ST_WAIT: w_state_nxt = ST_LOAD;
                ST_LOAD: begin
                    w_data_nxt  = rd_byte;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = user_crc && (r_cnt == {1'b0, r_len} + LAST_USER_OFS);
                    w_state_nxt = ST_SEND;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        w_valid_nxt = 1'b0;
                        w_crc_nxt   = w_crc_upd;
                        w_cnt_nxt   = w_cnt_inc;
                        if (r_cnt == OFS_LEN) begin
                            w_len_nxt = r_data;
                        end
                        if ((r_cnt == OFS_LEN) &&
                            (w_len_eff > (user_crc ? MAX_LEN_USER : MAX_LEN_CRC))) begin
                            w_error_nxt = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else if (!user_crc && (r_cnt == w_len_eff + LAST_PAY_OFS)) begin
                            w_data_nxt  = w_crc_upd[7:0];
                            w_valid_nxt = 1'b1;
                            w_last_nxt  = 1'b0;
                            w_state_nxt = ST_CRC_L;
                        end else if (user_crc && (r_cnt == w_len_eff + LAST_USER_OFS)) begin
                            w_last_nxt  = 1'b0;
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_rd_addr_nxt = w_cnt_inc[7:0];
                            w_state_nxt   = ST_WAIT;
                        end
                    end
                end
                ST_CRC_L: begin
                    if (w_hs) begin
                        w_data_nxt  = r_crc[15:8];
                        w_last_nxt  = 1'b1;
                        w_state_nxt = ST_CRC_H;
                    end
                end
                ST_CRC_H: begin
                    if (w_hs) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_FIN;
                    end
                end
                ST_FIN: begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rd_addr <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_crc     <= CRC_INIT;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_crc     <= w_crc_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign rd_addr   = r_rd_addr;
    assign ser_data  = r_data;
    assign ser_valid = r_valid;
    assign ser_last  = r_last;

endmodule
